// File: rtl/req_arbiter_rr.sv
// N-master burst arbiter in front of a single slave (e.g. the SDRAM controller).
// A grant is held from arbitration through the final data beat of the burst.
module req_arbiter_rr #(
    parameter int MASTERS = 2,
    parameter int LW      = 8,
    parameter int MW      = 4,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int RR      = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [MASTERS-1:0]    m_req_valid,
    output logic [MASTERS-1:0]    m_req_ready,
    input  logic [MASTERS*LW-1:0] m_req_len,
    input  logic [MASTERS*MW-1:0] m_req_mask,
    input  logic [MASTERS*AW-1:0] m_req_addr,
    input  logic [MASTERS-1:0]    m_req_we,
    input  logic [MASTERS-1:0]    m_req_wrap,
    input  logic [MASTERS-1:0]    m_write_valid,
    input  logic [MASTERS*DW-1:0] m_write_data,
    output logic [MASTERS-1:0]    m_read_valid,
    output logic [MASTERS*DW-1:0] m_read_data,
    input  logic [MASTERS-1:0]    m_read_ack,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [LW-1:0]         req_len,
    output logic [MW-1:0]         req_mask,
    output logic [AW-1:0]         req_addr,
    output logic                  req_we,
    output logic                  req_wrap,
    output logic                  write_valid,
    output logic [DW-1:0]         write_data,
    input  logic                  read_valid,
    input  logic [DW-1:0]         read_data,
    output logic                  read_ack,
    output logic [MASTERS-1:0]    grant,
    output logic                  busy
);

    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [MASTERS-1:0]   grant_r, grant_s;
    logic [IW-1:0]        rr_ptr_r, rr_ptr_s;
    logic [LW-1:0]        len_r, len_s;
    logic                 we_r, we_s;
    logic [LW-1:0]        cnt_r, cnt_s;

    logic [IW-1:0]        winner_s;
    logic [IW-1:0]        g_idx_s;
    logic                 any_req_s;
    logic                 req_fire_s;
    logic                 beat_s;
    logic                 last_beat_s;

    // Index of the single set bit of a one-hot vector (0 when empty).
    function automatic logic [IW-1:0] onehot_to_idx(input logic [MASTERS-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | IW'(i);
            end
        end
        return idx;
    endfunction

    // Lowest requesting index wins.
    function automatic logic [IW-1:0] pick_fixed(input logic [MASTERS-1:0] vec);
        logic [IW-1:0] idx;
        logic          found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (vec[i] && !found) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // First requester at or after last+1, wrapping modulo MASTERS.
    function automatic logic [IW-1:0] pick_rr(input logic [MASTERS-1:0] vec,
                                              input logic [IW-1:0]      last);
        logic [IW-1:0] idx;
        logic          found;
        int            start;
        int            j;
        idx   = '0;
        found = 1'b0;
        start = (int'(last) >= MASTERS - 1) ? 0 : int'(last) + 1;
        for (int k = 0; k < MASTERS; k++) begin
            j = start + k;
            if (j >= MASTERS) begin
                j = j - MASTERS;
            end
            if (vec[j] && !found) begin
                idx   = IW'(j);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Arbitration winner among the current requesters.
    always_comb begin
        winner_s = '0;
        if (MASTERS == 1) begin
            winner_s = '0;
        end else if (RR != 0) begin
            winner_s = pick_rr(m_req_valid, rr_ptr_r);
        end else begin
            winner_s = pick_fixed(m_req_valid);
        end
    end

    assign any_req_s = |m_req_valid;
    assign g_idx_s   = onehot_to_idx(grant_r);

    // Request fields always follow the granted master; valids are gated by state.
    always_comb begin
        req_len     = m_req_len[int'(g_idx_s)*LW +: LW];
        req_mask    = m_req_mask[int'(g_idx_s)*MW +: MW];
        req_addr    = m_req_addr[int'(g_idx_s)*AW +: AW];
        req_we      = m_req_we[g_idx_s];
        req_wrap    = m_req_wrap[g_idx_s];
        write_data  = m_write_data[int'(g_idx_s)*DW +: DW];
        req_valid   = 1'b0;
        m_req_ready = '0;
        write_valid = 1'b0;
        read_ack    = 1'b0;
        m_read_valid = '0;
        if (state_r == ST_REQ) begin
            req_valid   = m_req_valid[g_idx_s];
            m_req_ready = grant_r & {MASTERS{req_ready}};
        end else if (state_r == ST_DATA) begin
            if (we_r) begin
                write_valid = m_write_valid[g_idx_s];
            end else begin
                read_ack     = m_read_ack[g_idx_s];
                m_read_valid = read_valid ? grant_r : '0;
            end
        end else begin
            req_valid = 1'b0;
        end
    end

    assign m_read_data = {MASTERS{read_data}};
    assign req_fire_s  = req_valid && req_ready;
    assign beat_s      = we_r ? write_valid : (read_valid && read_ack);
    // Comparing against the latched length lets len = 2^LW-1 run 2^LW beats without overflow.
    assign last_beat_s = (state_r == ST_DATA) && beat_s && (cnt_r == len_r);

    // Next-state and burst bookkeeping.
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        rr_ptr_s = rr_ptr_r;
        len_s    = len_r;
        we_s     = we_r;
        cnt_s    = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_s  = MASTERS'(1) << winner_s;
                    rr_ptr_s = winner_s;
                    state_s  = ST_REQ;
                end else begin
                    grant_s  = '0;
                end
            end
            ST_REQ: begin
                if (req_fire_s) begin
                    len_s   = req_len;
                    we_s    = req_we;
                    cnt_s   = '0;
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DATA: begin
                if (last_beat_s) begin
                    state_s = ST_IDLE;
                    grant_s = '0;
                end else if (beat_s) begin
                    cnt_s = cnt_r + LW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // State registers; reset leaves master 0 with top round-robin priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= IW'(MASTERS - 1);
            len_r    <= '0;
            we_r     <= 1'b0;
            cnt_r    <= '0;
        end else begin
            state_r  <= state_s;
            grant_r  <= grant_s;
            rr_ptr_r <= rr_ptr_s;
            len_r    <= len_s;
            we_r     <= we_s;
            cnt_r    <= cnt_s;
        end
    end

    assign grant = grant_r;
    assign busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_req_arbiter_rr.sv
// Directed bench for req_arbiter_rr: a round-robin and a fixed-priority instance
// share the same master/slave stimulus.
module tb_req_arbiter_rr;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   m_req_valid, m_req_we, m_req_wrap, m_write_valid, m_read_ack;
    logic [31:0]  m_req_len;
    logic [15:0]  m_req_mask;
    logic [127:0] m_req_addr, m_write_data;
    logic         req_ready, read_valid;
    logic [31:0]  read_data;

    logic [3:0]   m_req_ready_a, m_read_valid_a, grant_a;
    logic [127:0] m_read_data_a;
    logic         req_valid_a, req_we_a, req_wrap_a, write_valid_a, read_ack_a, busy_a;
    logic [7:0]   req_len_a;
    logic [3:0]   req_mask_a;
    logic [31:0]  req_addr_a, write_data_a;

    logic [3:0]   m_req_ready_b, m_read_valid_b, grant_b;
    logic [127:0] m_read_data_b;
    logic         req_valid_b, req_we_b, req_wrap_b, write_valid_b, read_ack_b, busy_b;
    logic [7:0]   req_len_b;
    logic [3:0]   req_mask_b;
    logic [31:0]  req_addr_b, write_data_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    req_arbiter_rr #(.MASTERS(4), .LW(8), .MW(4), .DW(32), .AW(32), .RR(1)) dut_rr (
        .clk(clk), .rstn(rstn),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready_a), .m_req_len(m_req_len),
        .m_req_mask(m_req_mask), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_wrap(m_req_wrap), .m_write_valid(m_write_valid), .m_write_data(m_write_data),
        .m_read_valid(m_read_valid_a), .m_read_data(m_read_data_a), .m_read_ack(m_read_ack),
        .req_valid(req_valid_a), .req_ready(req_ready), .req_len(req_len_a),
        .req_mask(req_mask_a), .req_addr(req_addr_a), .req_we(req_we_a), .req_wrap(req_wrap_a),
        .write_valid(write_valid_a), .write_data(write_data_a), .read_valid(read_valid),
        .read_data(read_data), .read_ack(read_ack_a), .grant(grant_a), .busy(busy_a)
    );

    req_arbiter_rr #(.MASTERS(4), .LW(8), .MW(4), .DW(32), .AW(32), .RR(0)) dut_fp (
        .clk(clk), .rstn(rstn),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready_b), .m_req_len(m_req_len),
        .m_req_mask(m_req_mask), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_wrap(m_req_wrap), .m_write_valid(m_write_valid), .m_write_data(m_write_data),
        .m_read_valid(m_read_valid_b), .m_read_data(m_read_data_b), .m_read_ack(m_read_ack),
        .req_valid(req_valid_b), .req_ready(req_ready), .req_len(req_len_b),
        .req_mask(req_mask_b), .req_addr(req_addr_b), .req_we(req_we_b), .req_wrap(req_wrap_b),
        .write_valid(write_valid_b), .write_data(write_data_b), .read_valid(read_valid),
        .read_data(read_data), .read_ack(read_ack_b), .grant(grant_b), .busy(busy_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic v, input logic [7:0] len,
                              input logic we, input logic [31:0] addr);
        m_req_valid[i]        = v;
        m_req_len[i*8 +: 8]   = len;
        m_req_mask[i*4 +: 4]  = 4'hF;
        m_req_we[i]           = we;
        m_req_addr[i*32 +: 32] = addr;
    endtask

    // Step until the round-robin instance is in REQ (m_req_ready visible with req_ready high).
    task automatic wait_req(input string tag, input logic rdy_high);
        logic found;
        found = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (busy_a && !req_valid_a == 1'b0 && (m_req_ready_a != 4'b0 || !rdy_high)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_val(tag, 64'(found), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " grant"}, 64'(grant_a), 64'd0);
        check_val({tag, " busy"}, 64'(busy_a), 64'd0);
        check_val({tag, " req_valid"}, 64'(req_valid_a), 64'd0);
        check_val({tag, " write_valid"}, 64'(write_valid_a), 64'd0);
        check_val({tag, " read_ack"}, 64'(read_ack_a), 64'd0);
        check_val({tag, " m_req_ready"}, 64'(m_req_ready_a), 64'd0);
        check_val({tag, " m_read_valid"}, 64'(m_read_valid_a), 64'd0);
    endtask

    initial begin
        logic [3:0] exp_g;
        int         beats;
        int         bad;
        logic       done;

        rstn = 1'b0;
        m_req_valid = 4'h0; m_req_we = 4'h0; m_req_wrap = 4'h0;
        m_write_valid = 4'h0; m_read_ack = 4'h0;
        m_req_len = 32'h0; m_req_mask = 16'h0; m_req_addr = 128'h0; m_write_data = 128'h0;
        req_ready = 1'b0; read_valid = 1'b0; read_data = 32'h0;
        repeat (3) step();
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Single master 2 write burst, len=3.
        set_master(2, 1'b1, 8'd3, 1'b1, 32'h0000_1000);
        m_write_valid[2] = 1'b1;
        m_write_data[64 +: 32] = 32'hDEAD_BEEF;
        req_ready = 1'b1;
        #1;
        check_val("t1 idle req_valid", 64'(req_valid_a), 64'd0);
        step();
        check_val("t1 grant", 64'(grant_a), 64'h4);
        check_val("t1 busy", 64'(busy_a), 64'd1);
        check_val("t1 req_valid", 64'(req_valid_a), 64'd1);
        check_val("t1 req_addr", 64'(req_addr_a), 64'h1000);
        check_val("t1 req_len", 64'(req_len_a), 64'd3);
        check_val("t1 req_mask", 64'(req_mask_a), 64'hF);
        check_val("t1 m_req_ready", 64'(m_req_ready_a), 64'h4);
        check_val("t1 no write in REQ", 64'(write_valid_a), 64'd0);
        step();
        m_req_valid[2] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_write_data[64 +: 32] = 32'hA0 + 32'(b);
            #1;
            check_val("t1 write_valid", 64'(write_valid_a), 64'd1);
            check_val("t1 write_data", 64'(write_data_a), 64'hA0 + 64'(b));
            check_val("t1 busy in data", 64'(busy_a), 64'd1);
            step();
        end
        check_val("t1 grant released", 64'(grant_a), 64'd0);
        check_val("t1 busy released", 64'(busy_a), 64'd0);
        check_val("t1 no fifth beat", 64'(write_valid_a), 64'd0);
        m_write_valid = 4'h0;

        // All four request len=0 reads continuously; RR rotates, fixed starves 1..3.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) set_master(i, 1'b1, 8'd0, 1'b0, 32'h100 * i);
        read_valid = 1'b1;
        read_data = 32'h55AA;
        m_read_ack = 4'hF;
        for (int i = 0; i < 8; i++) begin
            exp_g = 4'(1 << (i % 4));
            wait_req("t2 arb timeout", 1'b1);
            check_val("t2 rr grant", 64'(grant_a), 64'(exp_g));
            check_val("t3 fp grant", 64'(grant_b), 64'h1);
            step();
            check_val("t2 rr read_valid", 64'(m_read_valid_a), 64'(exp_g));
            check_val("t3 fp read_valid", 64'(m_read_valid_b), 64'h1);
            check_val("t2 read_data", 64'(m_read_data_a[32*(i%4) +: 32]), 64'h55AA);
            step();
            check_val("t2 idle read_valid", 64'(m_read_valid_a), 64'd0);
        end

        // Long read burst, len=255 with read_ack toggling.
        m_req_valid = 4'h0;
        m_read_ack = 4'h0;
        set_master(1, 1'b1, 8'd255, 1'b0, 32'h2000);
        wait_req("t4 arb timeout", 1'b1);
        check_val("t4 grant", 64'(grant_a), 64'h2);
        step();
        m_req_valid[1] = 1'b0;
        beats = 0;
        bad = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (!busy_a) begin
                done = 1'b1;
                break;
            end
            m_read_ack[1] = cyc[0];
            #1;
            if ((m_read_valid_a & 4'b1101) != 4'b0) bad++;
            if (m_read_valid_a[1] && read_ack_a) beats++;
            step();
        end
        check_val("t4 burst ended", 64'(done), 64'd1);
        check_val("t4 acked beats", 64'(beats), 64'd256);
        check_val("t4 stray read_valid", 64'(bad), 64'd0);

        // req_ready held low in REQ while other masters pile up.
        read_valid = 1'b0;
        m_read_ack = 4'h0;
        req_ready = 1'b0;
        set_master(0, 1'b1, 8'd0, 1'b1, 32'h3000);
        wait_req("t5 arb timeout", 1'b0);
        check_val("t5 grant", 64'(grant_a), 64'h1);
        set_master(1, 1'b1, 8'd7, 1'b1, 32'h4000);
        set_master(2, 1'b1, 8'd0, 1'b0, 32'h5000);
        set_master(3, 1'b1, 8'd0, 1'b0, 32'h6000);
        for (int k = 0; k < 10; k++) begin
            #1;
            check_val("t5 grant stable", 64'(grant_a), 64'h1);
            check_val("t5 m_req_ready low", 64'(m_req_ready_a), 64'd0);
            check_val("t5 req_valid", 64'(req_valid_a), 64'd1);
            step();
        end
        req_ready = 1'b1;
        #1;
        check_val("t5 m_req_ready", 64'(m_req_ready_a), 64'h1);
        step();
        m_req_valid[0] = 1'b0;
        m_write_valid[0] = 1'b1;
        #1;
        check_val("t5 write beat", 64'(write_valid_a), 64'd1);
        step();
        m_write_valid[0] = 1'b0;
        check_val("t5 dead cycle grant", 64'(grant_a), 64'd0);
        step();
        check_val("t5 next rr grant", 64'(grant_a), 64'h2);

        // Reset in the middle of master 1's write burst.
        step();
        m_req_valid[1] = 1'b0;
        m_write_valid[1] = 1'b1;
        #1;
        check_val("t6 write active", 64'(write_valid_a), 64'd1);
        step();
        step();
        rstn = 1'b0;
        read_valid = 1'b1;
        m_read_ack = 4'hF;
        step();
        #1;
        check_reset_outputs("t6 reset");
        m_req_valid = 4'hF;
        rstn = 1'b1;
        step();
        check_val("t6 first grant", 64'(grant_a), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/req_arbiter_rr.md
# req_arbiter_rr

Parametrised N-master arbiter for the SoC request/write/read bus, generalising the two-master SDRAM arbiter to any master count, with selectable fixed-priority or round-robin policy. It sits between bus masters (CPU interface, VGA DMA, future DMA engines) and one slave such as the SDRAM controller. It holds a grant for the whole burst, counting data beats against the latched length, and releases it on the final beat.

## Interface
- MASTERS, 2: number of masters, 1..16
- LW, 8: burst length field width
- MW, 4: byte mask width
- DW, 32: data width
- AW, 32: address width
- RR, 1: 1 = round-robin, 0 = fixed priority (lowest index wins)
- Packing: master i occupies bits [i*W +: W] of every m_* vector.

Ports:
- clk  in  1  system clock; one clock; all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- m_req_valid / m_req_ready  in / out  MASTERS  per-master request handshake
- m_req_len  in  MASTERS*LW  beats minus one
- m_req_mask  in  MASTERS*MW  byte enables
- m_req_addr  in  MASTERS*AW  start address
- m_req_we / m_req_wrap  in  MASTERS  write flag / wrapping burst flag
- m_write_valid  in  MASTERS  write beat strobe
- m_write_data  in  MASTERS*DW  write data
- m_read_valid  out  MASTERS  read beat strobe, granted master only
- m_read_data  out  MASTERS*DW  slave read_data broadcast to all masters
- m_read_ack  in  MASTERS  master accepts read beat
- req_valid / req_ready  out / in  1  slave request handshake
- req_len, req_mask, req_addr, req_we, req_wrap  out  LW/MW/AW/1/1  muxed from granted master
- write_valid / write_data  out  1 / DW  muxed write beat
- read_valid / read_data  in  1 / DW  slave read beat
- read_ack  out  1  granted master's m_read_ack
- grant  out  MASTERS  one-hot registered grant, 0 when idle
- busy  out  1  high in REQ or DATA

## Operation
- States: IDLE, REQ, DATA.
- IDLE: if any m_req_valid, pick winner, register grant, go REQ. Otherwise stay, grant = 0.
- Fixed priority: lowest set index. Round-robin: search starts at (last_grant+1) mod MASTERS; pointer updates on each grant.
- REQ: req_valid = m_req_valid[g]; all req_* fields muxed from g. m_req_ready[g] = req_ready; other m_req_ready = 0. On req_valid && req_ready: latch len and we, clear beat counter, go DATA.
- DATA write (we=1): write_valid = m_write_valid[g], write_data muxed. Each write_valid cycle is one beat. Slave accepts one beat per cycle; no backpressure.
- DATA read (we=0): m_read_valid[g] = read_valid, others 0. read_ack = m_read_ack[g]. A beat is read_valid && read_ack.
- Final beat: beat with counter == latched len. Go IDLE, clear grant.
- Gating: write_valid = 0 and all m_read_valid = 0 outside DATA. Write beats presented in REQ are not forwarded; masters must not write before acceptance.
- Masters hold m_req_valid and fields stable until ready. If a granted master drops m_req_valid in REQ, the grant is held and req_valid goes 0.
- Length: counter is LW bits. len=0 is one beat. len=2^LW-1 is 2^LW beats, with no counter overflow.
- MASTERS=1: grant is always bit 0; arbitration logic reduces away.

## Timing
- Reset values: grant=0, busy=0, req_valid=0, write_valid=0, read_ack=0, m_req_ready=0, m_read_valid=0. State=IDLE, counter=0, RR pointer set so master 0 has highest priority.
- Reset mid-burst aborts immediately, with no completion to the slave; the slave is reset by the same rstn.
- Arbitration latency: m_req_valid high in IDLE at cycle 0 gives grant and req_valid at cycle 1.
- Request path is combinational from master to slave in REQ, and so is req_ready to m_req_ready.
- Release: final beat at cycle n, IDLE at n+1, next grant at n+2. There is one dead cycle between bursts.
- Simultaneous requests resolve only in IDLE. Grant never changes in REQ or DATA.
- A new request arriving during the final beat waits for IDLE.

## Test plan
- Single master, MASTERS=4, RR=1: master 2 write, len=3. Expect grant=4'b0100 at cycle 1, exactly 4 write beats forwarded, grant=0 after the final beat, busy low.
- All four masters request continuously, RR=1, len=0 reads, read_ack tied high. Expect grant order 0,1,2,3,0,… and each master gets one read_valid per burst.
- Same stimulus with RR=0. Expect master 0 granted every arbitration and masters 1–3 starved.
- Read len=255 (LW=8) with read_ack toggling 50%. Expect exactly 256 acked beats; m_read_valid only on the granted bit; counter does not wrap early.
- req_ready held low for 10 cycles in REQ while other masters assert. Expect grant stable, m_req_ready=0 for all masters, then proceed on ready.
- rstn low mid-DATA on a write burst. Next cycle: all outputs at reset values; first grant after reset goes to master 0.
